// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the MAC sequencing controller.
// State encodings and default widths.
package mac_seq_ctrl_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ACC_WIDTH = 20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mac_seq_ctrl_ripple_add.sv
// Ripple-carry adder built from single-bit full-adder cells.
// Shared by the multiply loop and the accumulate step.
module mac_full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module mac_ripple_add #(
  parameter int N = 20
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    mac_full_add u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[N];

endmodule

// File: rtl/mac_seq_ctrl.sv
// Shift-and-add MAC sequencer with valid/ready in and out.
// Define MAC_SAT_EN to saturate acc on carry-out instead of wrapping.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 clr_acc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 ovf,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  state_t                 state;
  logic [PW-1:0]          a_sh;
  logic [WIDTH-1:0]       b_sh;
  logic [PW-1:0]          prod;
  logic [CW-1:0]          cnt;

  logic [ACC_WIDTH-1:0]   add_a;
  logic [ACC_WIDTH-1:0]   add_b;
  logic [ACC_WIDTH-1:0]   add_sum;
  logic                   add_cout;

  assign in_ready = (state == S_IDLE);

  // One adder serves both phases; operands are steered by state.
  always_comb begin
    add_a = '0;
    add_b = '0;
    unique case (1'b1)
      (state == S_MULT): begin
        add_a = ACC_WIDTH'(prod);
        add_b = ACC_WIDTH'(a_sh);
      end
      (state == S_ACC): begin
        add_a = acc;
        add_b = ACC_WIDTH'(prod);
      end
      default: ;
    endcase
  end

  mac_ripple_add #(
    .N (ACC_WIDTH)
  ) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      prod      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr_acc) begin
            acc <= '0;
            ovf <= 1'b0;
          end
          if (in_valid) begin
            a_sh  <= PW'(a);
            b_sh  <= b;
            prod  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_MULT;
          end
        end
        S_MULT: begin
          if (b_sh[0]) begin
            prod <= add_sum[PW-1:0];
          end
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_ACC;
          end
        end
        S_ACC: begin
          if (add_cout) begin
            ovf <= 1'b1;
`ifdef MAC_SAT_EN
            acc <= '1;
`else
            acc <= add_sum;
`endif
          end else begin
            acc <= add_sum;
          end
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomised and directed bench for mac_seq_ctrl.
// Reference: arithmetic accumulator model, modular or saturating.
module tb_mac_seq_ctrl;

  localparam int W  = 8;
  localparam int AW = 20;
  localparam longint MOD = 64'd1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          clr_acc = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] acc;
  logic          ovf;
  logic          busy;

  int total = 0;
  int bad = 0;

  longint m_acc = 0;
  bit     m_ovf = 1'b0;

  mac_seq_ctrl #(
    .WIDTH     (W),
    .ACC_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .clr_acc   (clr_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_op(input int x, input int y, input bit clr);
    longint s;
    if (clr) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end
    s = m_acc + longint'(x) * longint'(y);
    if (s >= MOD) begin
      m_ovf = 1'b1;
`ifdef MAC_SAT_EN
      m_acc = MOD - 1;
`else
      m_acc = s % MOD;
`endif
    end else begin
      m_acc = s;
    end
  endtask

  // Present one operand pair and return just after the accept edge.
  task automatic send(input int x, input int y, input bit clr);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a        = W'(x);
    b        = W'(y);
    clr_acc  = clr;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_acc  = 1'b0;
    model_op(x, y, clr);
  endtask

  // Wait for the result, optionally stall out_ready, then release.
  task automatic finish(input int hold);
    int lat = 0;
    bit busy_ok = 1'b1;
    bit hold_ok = 1'b1;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (!busy || in_ready) busy_ok = 1'b0;
    end while (!out_valid && lat < 50);
    chk("latency", lat, W + 1);
    chk("busy_during_op", {31'd0, busy_ok}, 32'd1);
    chk("acc", acc, 32'(m_acc));
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || acc !== AW'(m_acc) || in_ready) hold_ok = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
    end
    if (hold > 0) chk("hold_stable", {31'd0, hold_ok}, 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", {31'd0, out_valid}, 32'd0);
    chk("release_ready", {31'd0, in_ready}, 32'd1);
    chk("release_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_acc", acc, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    send(3, 5, 1'b0);
    finish(0);
    chk("dir_3x5", acc, 32'd15);

    send(255, 255, 1'b0);
    finish(0);
    chk("dir_255x255", acc, 32'd65040);

    for (int i = 0; i < 17; i++) begin
      send(255, 255, i == 0);
      finish(0);
    end
`ifdef MAC_SAT_EN
    chk("dir_17x_acc", acc, 32'd1048575);
`else
    chk("dir_17x_acc", acc, 32'd56849);
`endif
    chk("dir_17x_ovf", {31'd0, ovf}, 32'd1);

    send(1, 2, 1'b0);
    finish(20);

    send(10, 10, 1'b1);
    finish(0);
    chk("dir_acc100", acc, 32'd100);
    send(2, 7, 1'b1);
    finish(0);
    chk("dir_clr_acc", acc, 32'd14);
    chk("dir_clr_ovf", {31'd0, ovf}, 32'd0);

    send(200, 3, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_acc", acc, 32'd0);
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_ready", {31'd0, in_ready}, 32'd1);
    chk("async_busy", {31'd0, busy}, 32'd0);
    m_acc = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(1, 1, 1'b0);
    finish(0);
    chk("post_rst_1x1", acc, 32'd1);

    for (int i = 0; i < 30; i++) begin
      send($urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 7) == 0);
      finish($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
